// File: rtl/sinc_comp_pkg.sv
// sinc_comp_pkg: shared sizes, FSM state type and the sinc3 droop
// compensation taps (Q2.14, DC gain 1.0) for sinc_comp_fir.
package sinc_comp_pkg;

    localparam int NTAPS_DEF = 8;
    localparam int DW_DEF    = 16;
    localparam int CW_DEF    = 16;

    // Accumulator width that cannot overflow: product width plus log2(taps).
    localparam int ACC_W = DW_DEF + CW_DEF + $clog2(NTAPS_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic signed [CW_DEF-1:0] COEF [NTAPS_DEF] = '{
        -16'sd128, 16'sd256, -16'sd512, 16'sd8576,
        16'sd8576, -16'sd512, 16'sd256, -16'sd128
    };

    // Coefficient lookup; taps beyond the table contribute nothing.
    function automatic logic signed [CW_DEF-1:0] coef_at(input int unsigned k);
        logic signed [CW_DEF-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < NTAPS_DEF; i++) begin
            if (k == i) begin
                c = COEF[i];
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/sinc_comp_mac.sv
// sinc_comp_mac: operand select, multiply, accumulate, round-half-up and
// output reduction for sinc_comp_fir. Define SINC_COMP_SAT_EN to clamp the
// rounded result to the DW range; otherwise it wraps to the low DW bits.
module sinc_comp_mac
    import sinc_comp_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEF,
    parameter int DW    = DW_DEF,
    parameter int CW    = CW_DEF,
    parameter int TW    = 3
) (
    input  logic                 mclk1,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 step,
    input  logic                 load,
    input  logic [DW-1:0]        taps [NTAPS],
    input  logic [TW-1:0]        tap,
    output logic signed [DW-1:0] dout,
    output logic                 dout_valid
);

    localparam int AW   = DW + CW + $clog2(NTAPS);
    localparam int FRAC = CW - 2;
    localparam logic signed [AW-1:0] HALF = {{(AW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
`ifdef SINC_COMP_SAT_EN
    localparam logic signed [AW-1:0] MAX_V = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] MIN_V = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
`endif

    logic signed [DW-1:0]    x_sel;
    logic signed [CW-1:0]    coef_sel;
    logic signed [DW+CW-1:0] prod;
    logic signed [AW-1:0]    acc_reg;
    logic signed [AW-1:0]    acc_next;
    logic signed [AW-1:0]    rnd;
    logic signed [DW-1:0]    res;

    // Pick the current tap's sample and coefficient and form the next sum.
    always_comb begin
        x_sel    = $signed(taps[tap]);
        coef_sel = CW'(coef_at(32'(tap)));
        prod     = x_sel * coef_sel;
        acc_next = acc_reg + AW'(prod);
    end

    // Round half up, then reduce to the output width.
    always_comb begin
        rnd = (acc_reg + HALF) >>> FRAC;
`ifdef SINC_COMP_SAT_EN
        if (rnd > MAX_V) begin
            res = MAX_V[DW-1:0];
        end else if (rnd < MIN_V) begin
            res = MIN_V[DW-1:0];
        end else begin
            res = rnd[DW-1:0];
        end
`else
        res = rnd[DW-1:0];
`endif
    end

`ifndef SINC_COMP_SAT_EN
    // Upper bits are intentionally discarded by the wrapping reduction.
    logic unused_rnd_bits;
    assign unused_rnd_bits = ^rnd[AW-1:DW];
`endif

    // Accumulator: cleared when a sample is accepted, one product per MAC cycle.
    always_ff @(posedge mclk1 or posedge reset) begin
        if (reset) begin
            acc_reg <= '0;
        end else if (clear) begin
            acc_reg <= '0;
        end else if (step) begin
            acc_reg <= acc_next;
        end
    end

    // Output register: updates only on load and holds between strobes.
    always_ff @(posedge mclk1 or posedge reset) begin
        if (reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= load;
            if (load) begin
                dout <= res;
            end
        end
    end

endmodule

// File: rtl/sinc_comp_fir.sv
// sinc_comp_fir: sequential single-MAC FIR compensating sinc3 droop.
// Holds the IDLE/MAC/OUT control FSM and the sample delay line; arithmetic
// lives in sinc_comp_mac. Define SINC_COMP_SAT_EN for saturating output.
module sinc_comp_fir
    import sinc_comp_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEF,
    parameter int DW    = DW_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic                 mclk1,
    input  logic                 reset,
    input  logic signed [DW-1:0] din,
    input  logic                 din_valid,
    output logic signed [DW-1:0] dout,
    output logic                 dout_valid,
    output logic                 busy,
    output logic                 overrun
);

    localparam int TW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam logic [TW-1:0] LAST_TAP = TW'(NTAPS - 1);

    state_t         state_reg;
    state_t         state_next;
    logic           accept;
    logic           step;
    logic           load;
    logic [TW-1:0]  tap_reg;
    logic [DW-1:0]  x_reg [NTAPS];
    logic           overrun_reg;

    // State register.
    always_ff @(posedge mclk1 or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and datapath strobes.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        step       = 1'b0;
        load       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (din_valid) begin
                    accept     = 1'b1;
                    state_next = MAC;
                end
            end
            MAC: begin
                step = 1'b1;
                if (tap_reg == LAST_TAP) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                load       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy    = (state_reg != IDLE);
    assign overrun = overrun_reg;

    // Tap index: restarts on acceptance, advances once per MAC cycle.
    always_ff @(posedge mclk1 or posedge reset) begin
        if (reset) begin
            tap_reg <= '0;
        end else if (accept) begin
            tap_reg <= '0;
        end else if (step) begin
            tap_reg <= tap_reg + TW'(1);
        end
    end

    // Delay line shifts only on acceptance, so dropped words never enter it.
    generate
        for (genvar gi = 0; gi < NTAPS; gi++) begin : g_delay
            if (gi == 0) begin : g_head
                // Newest sample enters stage 0.
                always_ff @(posedge mclk1 or posedge reset) begin
                    if (reset) begin
                        x_reg[gi] <= '0;
                    end else if (accept) begin
                        x_reg[gi] <= din;
                    end
                end
            end else begin : g_tail
                // Older stages take their predecessor.
                always_ff @(posedge mclk1 or posedge reset) begin
                    if (reset) begin
                        x_reg[gi] <= '0;
                    end else if (accept) begin
                        x_reg[gi] <= x_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    // Sticky overrun: a strobe seen while busy is lost.
    always_ff @(posedge mclk1 or posedge reset) begin
        if (reset) begin
            overrun_reg <= 1'b0;
        end else if (din_valid && busy) begin
            overrun_reg <= 1'b1;
        end
    end

    sinc_comp_mac #(
        .NTAPS (NTAPS),
        .DW    (DW),
        .CW    (CW),
        .TW    (TW)
    ) u_mac (
        .mclk1      (mclk1),
        .reset      (reset),
        .clear      (accept),
        .step       (step),
        .load       (load),
        .taps       (x_reg),
        .tap        (tap_reg),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

endmodule

// File: tb/tb_sinc_comp_fir.sv
// tb_sinc_comp_fir: bench for sinc_comp_fir at default parameters.
module tb_sinc_comp_fir;

    localparam int NTAPS = 8;

    logic               mclk1;
    logic               reset;
    logic signed [15:0] din;
    logic               din_valid;
    logic signed [15:0] dout;
    logic               dout_valid;
    logic               busy;
    logic               overrun;

    int n_chk;
    int n_err;
    int pulse_cnt;
    int hist[$];
    int coef_tb [NTAPS] = '{-128, 256, -512, 8576, 8576, -512, 256, -128};

    sinc_comp_fir #(
        .NTAPS (8),
        .DW    (16),
        .CW    (16)
    ) dut (
        .mclk1      (mclk1),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial mclk1 = 1'b0;
    always #5 mclk1 = ~mclk1;

    always @(negedge mclk1) begin
        if (dout_valid === 1'b1) pulse_cnt++;
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Filter output from the accepted-sample history (newest first).
    function automatic longint model_out();
        longint acc;
        longint r;
        logic [15:0] lo;
        acc = 0;
        for (int k = 0; k < NTAPS; k++) begin
            if (k < hist.size()) acc += longint'(hist[k]) * longint'(coef_tb[k]);
        end
        r = (acc + 8192) >>> 14;
`ifdef SINC_COMP_SAT_EN
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`else
        lo = r[15:0];
        r = longint'($signed(lo));
`endif
        return r;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        din_valid = 1'b0;
        repeat (3) @(negedge mclk1);
        reset = 1'b0;
        hist.delete();
        @(negedge mclk1);
    endtask

    // Present one word and check latency, value, pulse width and hold.
    task automatic send(input string tag, input int v, input int gap);
        longint exp;
        int lat;
        logic signed [15:0] held;
        hist.push_front(v);
        if (hist.size() > NTAPS) void'(hist.pop_back());
        exp = model_out();
        din = 16'(v);
        din_valid = 1'b1;
        @(negedge mclk1);
        din_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge mclk1);
            if (dout_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            chk({tag, "_timeout"}, 0, 1);
        end else begin
            chk({tag, "_lat"}, lat, NTAPS + 1);
            chk({tag, "_dout"}, longint'(dout), exp);
            $display("txn %s din=%0d dout=%0d exp=%0d lat=%0d", tag, v, dout, exp, lat);
            held = dout;
            if (gap > 0) begin
                @(negedge mclk1);
                chk({tag, "_pulse"}, longint'(dout_valid), 0);
                chk({tag, "_hold"}, longint'(dout), longint'(held));
                repeat (gap - 1) @(negedge mclk1);
            end
        end
    endtask

    initial begin
        int w;
        int p0;
        longint exp;
        n_chk = 0;
        n_err = 0;
        pulse_cnt = 0;
        reset = 1'b1;
        din = '0;
        din_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge mclk1);
        chk("rst_dout", longint'(dout), 0);
        chk("rst_valid", longint'(dout_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_overrun", longint'(overrun), 0);
        reset = 1'b0;
        @(negedge mclk1);

        // Impulse response, samples spaced 10 cycles apart
        send("imp0", 16384, 10);
        for (int i = 1; i < NTAPS; i++) send("imp", 0, 10);

        // DC gain, back-to-back samples
        for (int i = 0; i < NTAPS; i++) send("dc", 1000, 0);
        chk("dc_final", longint'(dout), 1000);

        // Overflow pattern
        do_reset();
        send("ovf", -32767, 1); send("ovf", 32767, 1);
        send("ovf", -32767, 1); send("ovf", 32767, 1);
        send("ovf", 32767, 1);  send("ovf", -32767, 1);
        send("ovf", 32767, 1);  send("ovf", -32767, 2);
`ifdef SINC_COMP_SAT_EN
        chk("ovf_final", longint'(dout), 32767);
`else
        chk("ovf_final", longint'(dout), -27649);
`endif

        // Random samples with random gaps, including next-word-at-edge-10
        for (int i = 0; i < 24; i++) begin
            w = int'($urandom_range(65535)) - 32768;
            send("rnd", w, int'($urandom_range(3)));
        end
        chk("thr_overrun", longint'(overrun), 0);

        // Overrun: second strobe 4 cycles after the first is dropped
        do_reset();
        hist.push_front(12000);
        exp = model_out();
        p0 = pulse_cnt;
        din = 16'sd12000;
        din_valid = 1'b1;
        @(negedge mclk1);
        din_valid = 1'b0;
        repeat (3) @(negedge mclk1);
        din = -16'sd20000;
        din_valid = 1'b1;
        @(negedge mclk1);
        din_valid = 1'b0;
        chk("ovr_flag", longint'(overrun), 1);
        repeat (20) @(negedge mclk1);
        chk("ovr_pulses", longint'(pulse_cnt - p0), 1);
        chk("ovr_dout", longint'(dout), exp);
        $display("txn ovr din=12000 dout=%0d exp=%0d", dout, exp);
        send("ovr_next", 3000, 2);
        chk("ovr_sticky", longint'(overrun), 1);

        // Reset asserted mid-MAC aborts the computation
        do_reset();
        p0 = pulse_cnt;
        din = 16'sd1234;
        din_valid = 1'b1;
        @(negedge mclk1);
        din_valid = 1'b0;
        repeat (3) @(negedge mclk1);
        reset = 1'b1;
        repeat (2) @(negedge mclk1);
        reset = 1'b0;
        hist.delete();
        repeat (20) @(negedge mclk1);
        chk("abort_pulses", longint'(pulse_cnt - p0), 0);
        chk("abort_dout", longint'(dout), 0);
        chk("abort_overrun", longint'(overrun), 0);
        chk("abort_busy", longint'(busy), 0);
        $display("txn abort dout=%0d overrun=%0d", dout, overrun);
        send("post_abort", 20000, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sinc_comp_fir.md
SINC_COMP_FIR -- requirements
Module: sinc_comp_fir

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named mclk1 and reset.
REQ-002 The block SHALL have parameter NTAPS, default 8, giving the number of FIR taps.
REQ-003 The block SHALL have parameter DW, default 16, giving the sample width in and out (signed).
REQ-004 The block SHALL have parameter CW, default 16, giving the coefficient width (signed Q2.14).
REQ-005 mclk1  input  1  clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 din  input  DW  signed 16-bit word from the sinc3 decimator, already in the mclk1 domain.
REQ-008 din_valid  input  1  one-cycle strobe qualifying din.
REQ-009 dout  output  DW  signed compensated output word.
REQ-010 dout_valid  output  1  one-cycle strobe qualifying dout.
REQ-011 busy  output  1  high whenever state is not IDLE (combinational from state).
REQ-012 overrun  output  1  sticky flag indicating a dropped input word.

Function
REQ-013 The FSM SHALL have states IDLE, MAC and OUT.
REQ-014 In IDLE with din_valid=1, the block SHALL shift the delay line (x[0]<=din, x[k]<=x[k-1]), clear the accumulator, set tap index to 0 and enter MAC.
REQ-015 In MAC, the block SHALL perform acc += x[k]*COEF[k] once per cycle for k=0..NTAPS-1, then enter OUT after k=NTAPS-1.
REQ-016 The accumulator SHALL be signed, DW+CW+clog2(NTAPS) bits wide (35 at defaults), and SHALL never overflow.
REQ-017 In OUT, the block SHALL register dout=(acc+8192)>>>14 (round half up), reduced to DW per REQ-026/027, pulse dout_valid for one cycle, and return to IDLE.
REQ-018 Latency: if din_valid is sampled at edge 0, dout_valid SHALL be high in the cycle after edge NTAPS+1 (edge 9 at defaults).
REQ-019 Throughput: the earliest next accepted word SHALL be at edge NTAPS+2.
REQ-020 A din_valid arriving while busy=1 SHALL be dropped, leaving the delay line untouched, and SHALL set overrun, which stays high until reset.
REQ-021 dout SHALL hold its last value between dout_valid pulses.

Reset
REQ-022 While reset is high, state SHALL be IDLE, and delay line, accumulator, tap index, dout, dout_valid and overrun SHALL be 0.
REQ-023 Assertion of reset mid-MAC or mid-OUT SHALL abort the computation with no dout_valid pulse produced.
REQ-024 The first din_valid after reset deassertion SHALL be accepted normally.

Configuration
REQ-025 The block SHALL use the macro SINC_COMP_SAT_EN.
REQ-026 With SINC_COMP_SAT_EN defined, a rounded result above 32767 or below -32768 SHALL clamp to 32767 or -32768 respectively.
REQ-027 Without SINC_COMP_SAT_EN, the rounded result SHALL be truncated to its low DW bits (two's-complement wrap).

Structure
REQ-028 Package sinc_comp_pkg SHALL hold NTAPS_DEF, ACC_W, the state enum, and COEF = {-128, 256, -512, 8576, 8576, -512, 256, -128} (DC gain 1.0).
REQ-029 The multiply-accumulate datapath (operand select, multiply, accumulate, round and saturate) SHALL be one sub-module, sinc_comp_mac; the FSM and delay line SHALL live in the top level.

Verification
REQ-030 Impulse: din=16384 followed by seven din=0 (spaced 10 cycles) -> dout sequence -128, 256, -512, 8576, 8576, -512, 256, -128.
REQ-031 DC: eight din=1000 -> eighth dout=1000.
REQ-032 Overflow: din sequence -32767, 32767, -32767, 32767, 32767, -32767, 32767, -32767 -> eighth dout=32767 with SINC_COMP_SAT_EN, -27649 without.
REQ-033 Overrun: second din_valid 4 cycles after the first -> overrun=1, only one dout_valid pulse, and the delay line holds only the first word.
REQ-034 Latency and throughput: din_valid at edge 0 -> dout_valid in the cycle after edge 9; din_valid at edge 10 is accepted with overrun=0.
REQ-035 Reset during MAC at edge 4 -> no dout_valid pulse, dout=0, overrun=0, and the next sample processes correctly.
